// File: rtl/cnt_pkg.sv
// Shared constants and parameter-legality helper for the modulo-N counter family.
package cnt_pkg;

    localparam logic CNT_UP = 1'b1;
    localparam logic CNT_DN = 1'b0;

    // Legal: 1 <= width <= 32 and 2 <= modulus <= 2**width
    function automatic bit modulus_legal(input int unsigned width, input longint unsigned modulus);
        return (width >= 32'd1) && (width <= 32'd32) &&
               (modulus >= 64'd2) && (modulus <= (64'd1 << width));
    endfunction

endpackage

// File: rtl/cnt_next_state.sv
// Combinational next-state logic for param_mod_counter: load/count/hold, wrap and terminal.
module cnt_next_state
    import cnt_pkg::*;
#(
    parameter int unsigned      WIDTH   = 4,
    parameter longint unsigned  MODULUS = 16
) (
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    input  logic             ld_n,
    input  logic             ctp,
    input  logic             ctt,
    input  logic             ud,
    output logic [WIDTH-1:0] next_q,
    output logic             wrap_next,
    output logic             terminal
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 64'd1);

    // Priority: load > count > hold; out-of-range values wrap on the next count
    always_comb begin
        next_q    = q;
        wrap_next = 1'b0;
        terminal  = (ud == CNT_UP) ? (q == MAX_Q) : (q == '0);
        if (!ld_n) begin
            next_q = d;
        end else if (ctp && ctt) begin
            if (ud == CNT_UP) begin
                if (q >= MAX_Q) begin
                    next_q    = '0;
                    wrap_next = 1'b1;
                end else begin
                    next_q = q + WIDTH'(1);
                end
            end else begin
                if ((q == '0) || (64'(q) >= MODULUS)) begin
                    next_q    = MAX_Q;
                    wrap_next = 1'b1;
                end else begin
                    next_q = q - WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: rtl/param_mod_counter.sv
// Parametrised modulo-N counter with load, P/T enables, ripple carry and registered wrap flag.
// Define CNT_UPDOWN_EN to add the UD direction port (default build counts up only).
module param_mod_counter
    import cnt_pkg::*;
#(
    parameter int unsigned      WIDTH   = 4,
    parameter longint unsigned  MODULUS = 16
) (
    input  logic             CP,
    input  logic             CR,
    input  logic             LD,
    input  logic             CTP,
    input  logic             CTT,
    input  logic [WIDTH-1:0] D,
`ifdef CNT_UPDOWN_EN
    input  logic             UD,
`endif
    output logic [WIDTH-1:0] Q,
    output logic             Co,
    output logic             WRAP
);

    if (!modulus_legal(WIDTH, MODULUS)) begin : g_bad_modulus
        $error("param_mod_counter: illegal WIDTH/MODULUS combination");
    end

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             wrap_q;
    logic             wrap_d;
    logic             terminal_c;
    logic             ud_c;

`ifdef CNT_UPDOWN_EN
    assign ud_c = UD;
`else
    assign ud_c = CNT_UP;
`endif

    cnt_next_state #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_next (
        .q         (q_q),
        .d         (D),
        .ld_n      (LD),
        .ctp       (CTP),
        .ctt       (CTT),
        .ud        (ud_c),
        .next_q    (q_d),
        .wrap_next (wrap_d),
        .terminal  (terminal_c)
    );

    always_ff @(posedge CP or posedge CR) begin
        if (CR) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

    // Carry is combinational so cascaded stages see it within the same cycle
    assign Co   = CTT & terminal_c;
    assign Q    = q_q;
    assign WRAP = wrap_q;

endmodule

// File: tb/tb_param_mod_counter.sv
// Scoreboard bench for param_mod_counter (WIDTH=4, MODULUS=10), single stage and BCD cascade.
module tb_param_mod_counter;

    logic       cp;
    logic       cr;
    logic       ld;
    logic       ctp;
    logic       ctt;
    logic [3:0] d;
    logic [3:0] q0;
    logic [3:0] q1;
    logic       co0;
    logic       co1;
    logic       wrap0;
    logic       wrap1;
`ifdef CNT_UPDOWN_EN
    logic       ud;
`endif

    typedef struct {
        string      name;
        logic [3:0] q;
        logic       wrap;
        logic       co;
        bit         cas;
        logic [3:0] q1;
        logic       wrap1;
        logic       co1;
    } exp_t;

    exp_t sb[$];
    event chk_ev;
    int   n_pass = 0;
    int   n_chk  = 0;

    param_mod_counter #(.WIDTH(4), .MODULUS(10)) dut0 (
        .CP(cp), .CR(cr), .LD(ld), .CTP(ctp), .CTT(ctt), .D(d),
`ifdef CNT_UPDOWN_EN
        .UD(ud),
`endif
        .Q(q0), .Co(co0), .WRAP(wrap0)
    );

    param_mod_counter #(.WIDTH(4), .MODULUS(10)) dut1 (
        .CP(cp), .CR(cr), .LD(ld), .CTP(ctp), .CTT(co0), .D(d),
`ifdef CNT_UPDOWN_EN
        .UD(ud),
`endif
        .Q(q1), .Co(co1), .WRAP(wrap1)
    );

    initial cp = 1'b0;
    always #5 cp = ~cp;

    task automatic cmp(input string nm, input string fld, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s.%s: got %0h, expected %0h", nm, fld, act, exp);
    endtask

    // Monitor: compares at each falling edge, or immediately on an asynchronous check request
    initial begin
        exp_t e;
        forever begin
            @(negedge cp or chk_ev);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                cmp(e.name, "Q",    8'(q0),    8'(e.q));
                cmp(e.name, "WRAP", 8'(wrap0), 8'(e.wrap));
                cmp(e.name, "Co",   8'(co0),   8'(e.co));
                if (e.cas) begin
                    cmp(e.name, "Q1",    8'(q1),    8'(e.q1));
                    cmp(e.name, "WRAP1", 8'(wrap1), 8'(e.wrap1));
                    cmp(e.name, "Co1",   8'(co1),   8'(e.co1));
                end
            end
        end
    end

    task automatic push(input string nm, input logic [3:0] eq, input logic ew, input logic ec,
                        input bit cas, input logic [3:0] eq1, input logic ew1, input logic ec1);
        exp_t e;
        e.name = nm; e.q = eq; e.wrap = ew; e.co = ec;
        e.cas = cas; e.q1 = eq1; e.wrap1 = ew1; e.co1 = ec1;
        sb.push_back(e);
    endtask

    // Drive controls, take one edge, expect the post-edge state at the following falling edge
    task automatic cyc(input logic l, input logic p, input logic t, input logic [3:0] dv,
                       input string nm, input logic [3:0] eq, input logic ew, input logic ec);
        ld = l; ctp = p; ctt = t; d = dv;
        @(posedge cp);
        #1;
        push(nm, eq, ew, ec, 1'b0, 4'd0, 1'b0, 1'b0);
        @(negedge cp);
        #1;
    endtask

    task automatic chk_now(input string nm, input logic [3:0] eq, input logic ew, input logic ec);
        push(nm, eq, ew, ec, 1'b0, 4'd0, 1'b0, 1'b0);
        -> chk_ev;
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] t1_q [12];
        t1_q = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};

        cr = 1'b1; ld = 1'b1; ctp = 1'b0; ctt = 1'b1; d = 4'd0;
`ifdef CNT_UPDOWN_EN
        ud = 1'b1;
`endif
        // Test 1: reset held 30ns, then 12 counting edges
        #20;
        chk_now("t1_reset", 4'd0, 1'b0, 1'b0);
        #9;
        cr = 1'b0;
        for (int i = 0; i < 12; i++)
            cyc(1'b1, 1'b1, 1'b1, 4'd0, "t1_count", t1_q[i], (i == 9), (t1_q[i] == 4'd9));

        // Test 2: out-of-range load wraps to 0 on the next count
        cyc(1'b0, 1'b1, 1'b1, 4'd12, "t2_load12", 4'd12, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 4'd0,  "t2_oor_wrap", 4'd0, 1'b1, 1'b0);

        // Test 3: hold at 9 with only CTT, then drop CTT
        cyc(1'b0, 1'b0, 1'b1, 4'd9, "t3_load9", 4'd9, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 1'b0, 1'b1, 4'd0, "t3_hold", 4'd9, 1'b0, 1'b1);
        ctt = 1'b0;
        #1;
        chk_now("t3_ctt_drop", 4'd9, 1'b0, 1'b0);

        // Wrap, then asynchronous reset mid-cycle clears WRAP
        cyc(1'b1, 1'b1, 1'b1, 4'd0, "t3_wrap", 4'd0, 1'b1, 1'b0);
        cr = 1'b1;
        #1;
        chk_now("cr_clears_wrap", 4'd0, 1'b0, 1'b0);
        cr = 1'b0;

        // Test 4: asynchronous reset at Q=5 with a pending load of 7
        cyc(1'b0, 1'b0, 1'b0, 4'd5, "t4_load5", 4'd5, 1'b0, 1'b0);
        ld = 1'b0; d = 4'd7; ctp = 1'b1; ctt = 1'b1;
        #1;
        cr = 1'b1;
        #1;
        chk_now("t4_async_rst", 4'd0, 1'b0, 1'b0);
        cr = 1'b0;
        cyc(1'b0, 1'b1, 1'b1, 4'd7, "t4_load7", 4'd7, 1'b0, 1'b0);

        // Test 5: two-stage BCD cascade, 100 edges from 00
        cr = 1'b1;
        #1;
        cr = 1'b0;
        ld = 1'b1; ctp = 1'b1; ctt = 1'b1; d = 4'd0;
        for (int k = 1; k <= 100; k++) begin
            logic [3:0] u;
            logic [3:0] t;
            u = 4'(k % 10);
            t = 4'((k / 10) % 10);
            @(posedge cp);
            #1;
            push("t5_bcd", u, (u == 4'd0), (u == 4'd9), 1'b1,
                 t, ((k % 100) == 0), ((t == 4'd9) && (u == 4'd9)));
            @(negedge cp);
            #1;
        end

        // Test 6: direction
        cyc(1'b0, 1'b0, 1'b1, 4'd1, "t6_load1", 4'd1, 1'b0, 1'b0);
`ifdef CNT_UPDOWN_EN
        ud = 1'b0;
        cyc(1'b1, 1'b1, 1'b1, 4'd0, "t6_dn0", 4'd0, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 4'd0, "t6_dn9", 4'd9, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 4'd0, "t6_dn8", 4'd8, 1'b0, 1'b0);
`else
        cyc(1'b1, 1'b1, 1'b1, 4'd0, "t6_up2", 4'd2, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 4'd0, "t6_up3", 4'd3, 1'b0, 1'b0);
`endif

        repeat (2) @(negedge cp);
        #1;
        if (sb.size() != 0) begin
            n_chk++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
